// File: rtl/mc_pkg.sv
// Purpose : shared encodings for the multicycle RV32I-subset sequencer (states, opcodes, mux selects).
// Latency : n/a (constants and types only).
// Backpressure: n/a.
// Ports   : none. Consumers import mc_pkg::*.
package mc_pkg;

   // State encodings, FETCH must stay at zero so a cleared register means FETCH.
   localparam logic [3:0] ST_FETCH    = 4'd0;
   localparam logic [3:0] ST_DECODE   = 4'd1;
   localparam logic [3:0] ST_MEMADR   = 4'd2;
   localparam logic [3:0] ST_MEMREAD  = 4'd3;
   localparam logic [3:0] ST_MEMWB    = 4'd4;
   localparam logic [3:0] ST_MEMWRITE = 4'd5;
   localparam logic [3:0] ST_EXECR    = 4'd6;
   localparam logic [3:0] ST_EXECI    = 4'd7;
   localparam logic [3:0] ST_ALUWB    = 4'd8;
   localparam logic [3:0] ST_BEQ      = 4'd9;
   localparam logic [3:0] ST_JAL      = 4'd10;
   localparam logic [3:0] ST_FAULT    = 4'd11;

   typedef enum logic [3:0] {
      S_FETCH    = ST_FETCH,
      S_DECODE   = ST_DECODE,
      S_MEMADR   = ST_MEMADR,
      S_MEMREAD  = ST_MEMREAD,
      S_MEMWB    = ST_MEMWB,
      S_MEMWRITE = ST_MEMWRITE,
      S_EXECR    = ST_EXECR,
      S_EXECI    = ST_EXECI,
      S_ALUWB    = ST_ALUWB,
      S_BEQ      = ST_BEQ,
      S_JAL      = ST_JAL,
      S_FAULT    = ST_FAULT
   } state_e;

   // Opcode field values
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // ALU operand A select
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALU operand B select
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result select
   localparam logic [1:0] RES_ALUOUT  = 2'b00;
   localparam logic [1:0] RES_MEMDATA = 2'b01;
   localparam logic [1:0] RES_ALU     = 2'b10;

   // ALU operation class handed to the ALU-control decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_wait_timer.sv
// Purpose : memory wait-cycle counter for the sequencer watchdog; flags when the count reaches MEM_TIMEOUT.
// Latency : count updates on the clock edge; timeout is a combinational decode of the registered count.
// Backpressure: none; clear has priority over increment.
// Ports   : clk, rst_n (sync, active-low), clr (restart count), inc (one more wait cycle), timeout (count == MEM_TIMEOUT).
module mc_wait_timer #(
   parameter int CNT_W       = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic timeout
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LIMIT = MEM_TIMEOUT[CNT_W-1:0];

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout = (cnt_q == CNT_LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Purpose : Moore main sequencer for the multicycle RV32I-subset core (lw, sw, R-type, addi-class, beq; jal when MC_JAL_EN is defined).
// Latency : zero-wait memory gives lw 5, sw 4, R/I 4, beq 3 cycles; every memory state stalls until mem_ready.
// Backpressure: mem_req held until mem_ready; MEM_TIMEOUT wait cycles without mem_ready drives the sticky FAULT state.
// Ports   : clk, rst_n (sync, active-low); in: op[6:0], zero, mem_ready;
//           out: mem_req, mem_write, adr_src, ir_write, pc_write, alu_src_a[1:0], alu_src_b[1:0],
//                result_src[1:0], reg_write, aluop[1:0], state_o[3:0], fault.
// Config  : define MC_JAL_EN to add the JAL state; otherwise op 1101111 is illegal.
module multicycle_control
   import mc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic       reg_write,
   output logic [1:0] aluop,
   output logic [3:0] state_o,
   output logic       fault
);

   state_e state_q;
   state_e state_d;

   // Ungated enables straight from the state decode
   logic mem_req_raw;
   logic mem_write_raw;
   logic ir_write_raw;
   logic reg_write_raw;
   logic pc_update;
   logic branch;

   logic tmr_timeout;
   logic wd_expire;
   logic en_ok;

   mc_wait_timer #(
      .CNT_W       (CNT_W),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (state_d != state_q),
      .inc     (mem_req_raw & ~mem_ready),
      .timeout (tmr_timeout)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      mem_req_raw   = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      pc_update     = 1'b0;
      branch        = 1'b0;
      adr_src       = 1'b0;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_RS2;
      result_src    = RES_ALUOUT;
      aluop         = ALUOP_ADD;

      case (state_q)
         S_FETCH: begin
            mem_req_raw = 1'b1;
            alu_src_a   = SRCA_PC;
            alu_src_b   = SRCB_FOUR;
            result_src  = RES_ALU;
            if (mem_ready) begin
               ir_write_raw = 1'b1;
               pc_update    = 1'b1;
               state_d      = S_DECODE;
            end
         end
         S_DECODE: begin
            // Branch target is formed here from oldPC + imm and parked in ALUOut
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BEQ;
`ifdef MC_JAL_EN
               OP_JAL:            state_d = S_JAL;
`endif
               default:           state_d = S_FAULT;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            // op[5] separates store (0100011) from load (0000011)
            state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_req_raw = 1'b1;
            adr_src     = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src    = RES_MEMDATA;
            reg_write_raw = 1'b1;
            state_d       = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req_raw   = 1'b1;
            mem_write_raw = 1'b1;
            adr_src       = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            aluop     = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            aluop     = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            result_src    = RES_ALUOUT;
            reg_write_raw = 1'b1;
            state_d       = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            aluop      = ALUOP_SUB;
            result_src = RES_ALUOUT;
            branch     = 1'b1;
            state_d    = S_FETCH;
         end
`ifdef MC_JAL_EN
         S_JAL: begin
            // ALU computes the link value oldPC+4 while PC loads the DECODE target from ALUOut
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            aluop      = ALUOP_ADD;
            result_src = RES_ALUOUT;
            pc_update  = 1'b1;
            state_d    = S_ALUWB;
         end
`endif
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_FAULT;
         end
      endcase

      // Watchdog expiry overrides the state decode; a same-cycle mem_ready still wins
      if (wd_expire) state_d = S_FAULT;
      if (!rst_n)    state_d = S_FETCH;
   end

   assign wd_expire = tmr_timeout & mem_req_raw & ~mem_ready;

   // Enables are suppressed while in reset and in the cycle the watchdog fires
   assign en_ok = rst_n & ~wd_expire;

   assign mem_req   = mem_req_raw   & en_ok;
   assign mem_write = mem_write_raw & en_ok;
   assign ir_write  = ir_write_raw  & en_ok;
   assign reg_write = reg_write_raw & en_ok;
   assign pc_write  = (pc_update | (branch & zero)) & en_ok;

   assign state_o = state_q;
   assign fault   = (state_q == S_FAULT);

endmodule

// File: tb/tb_multicycle_control.sv
// Purpose : self-checking bench for multicycle_control using a per-cycle vector table and an expected-output queue.
// Latency : one table row per clock; outputs sampled 1 time unit after inputs change on the falling edge.
// Backpressure: n/a; the bench drives mem_ready directly from the table.
module tb_multicycle_control;
   import mc_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] op = 7'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, fault;
   logic [1:0] alu_src_a, alu_src_b, result_src, aluop;
   logic [3:0] state_o;

   multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op         (op),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_write  (mem_write),
      .adr_src    (adr_src),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .result_src (result_src),
      .reg_write  (reg_write),
      .aluop      (aluop),
      .state_o    (state_o),
      .fault      (fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       req;
      logic       wr;
      logic       adr;
      logic       irw;
      logic       pcw;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [1:0] rs;
      logic       rw;
      logic [1:0] ao;
      logic       flt;
   } out_t;

   typedef struct {
      string      tag;
      logic       rst;
      logic [6:0] op;
      logic       mr;
      logic       z;
      out_t       exp;
   } vec_t;

   vec_t vecs[$];
   out_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   function automatic out_t ex(int st, int req, int wr, int adr, int irw, int pcw,
                               int sa, int sb, int rs, int rw, int ao, int flt);
      out_t r;
      r.st  = 4'(st);
      r.req = 1'(req);
      r.wr  = 1'(wr);
      r.adr = 1'(adr);
      r.irw = 1'(irw);
      r.pcw = 1'(pcw);
      r.sa  = 2'(sa);
      r.sb  = 2'(sb);
      r.rs  = 2'(rs);
      r.rw  = 1'(rw);
      r.ao  = 2'(ao);
      r.flt = 1'(flt);
      return r;
   endfunction

   //                     st  req wr adr irw pcw sa sb rs rw ao flt
   out_t FETCH_OK, FETCH_WAIT, FETCH_GATED, DEC, MADR, MRD, MWBK, MWR, MWR_RST;
   out_t EXR, EXI, AWB, BQ1, BQ0, JL, FLT;

   task automatic add(string tag, logic rst, logic [6:0] o, logic mr, logic z, out_t e);
      vec_t v;
      v.tag = tag; v.rst = rst; v.op = o; v.mr = mr; v.z = z; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic check_val(string tag, logic [3:0] got, logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   initial begin
      out_t got;
      out_t exp;

      FETCH_OK    = ex(0, 1,0,0,1,1, 0,2,2,0,0,0);
      FETCH_WAIT  = ex(0, 1,0,0,0,0, 0,2,2,0,0,0);
      FETCH_GATED = ex(0, 0,0,0,0,0, 0,2,2,0,0,0);
      DEC         = ex(1, 0,0,0,0,0, 1,1,0,0,0,0);
      MADR        = ex(2, 0,0,0,0,0, 2,1,0,0,0,0);
      MRD         = ex(3, 1,0,1,0,0, 0,0,0,0,0,0);
      MWBK        = ex(4, 0,0,0,0,0, 0,0,1,1,0,0);
      MWR         = ex(5, 1,1,1,0,0, 0,0,0,0,0,0);
      MWR_RST     = ex(5, 0,0,1,0,0, 0,0,0,0,0,0);
      EXR         = ex(6, 0,0,0,0,0, 2,0,0,0,2,0);
      EXI         = ex(7, 0,0,0,0,0, 2,1,0,0,2,0);
      AWB         = ex(8, 0,0,0,0,0, 0,0,0,1,0,0);
      BQ1         = ex(9, 0,0,0,0,1, 2,0,0,0,1,0);
      BQ0         = ex(9, 0,0,0,0,0, 2,0,0,0,1,0);
      JL          = ex(10,0,0,0,0,1, 1,2,0,0,0,0);
      FLT         = ex(11,0,0,0,0,0, 0,0,0,0,0,1);

      // reset state with enables gated
      add("reset_hold", 0, 7'h33, 1, 0, FETCH_GATED);
      // R-type add, zero wait
      add("add_fetch",  1, 7'h33, 1, 0, FETCH_OK);
      add("add_dec",    1, 7'h33, 1, 0, DEC);
      add("add_execr",  1, 7'h33, 1, 0, EXR);
      add("add_aluwb",  1, 7'h33, 1, 0, AWB);
      // addi
      add("addi_fetch", 1, 7'h13, 1, 0, FETCH_OK);
      add("addi_dec",   1, 7'h13, 1, 0, DEC);
      add("addi_execi", 1, 7'h13, 1, 0, EXI);
      add("addi_aluwb", 1, 7'h13, 1, 0, AWB);
      // lw with three wait cycles in MEMREAD
      add("lw_fetch",   1, 7'h03, 1, 0, FETCH_OK);
      add("lw_dec",     1, 7'h03, 1, 0, DEC);
      add("lw_memadr",  1, 7'h03, 1, 0, MADR);
      for (int i = 0; i < 3; i++) add("lw_memrd_wait", 1, 7'h03, 0, 0, MRD);
      add("lw_memrd_done", 1, 7'h03, 1, 0, MRD);
      add("lw_memwb",   1, 7'h03, 1, 0, MWBK);
      // sw, zero wait
      add("sw_fetch",   1, 7'h23, 1, 0, FETCH_OK);
      add("sw_dec",     1, 7'h23, 1, 0, DEC);
      add("sw_memadr",  1, 7'h23, 1, 0, MADR);
      add("sw_memwr",   1, 7'h23, 1, 0, MWR);
      // beq taken then not taken
      add("beq1_fetch", 1, 7'h63, 1, 1, FETCH_OK);
      add("beq1_dec",   1, 7'h63, 1, 1, DEC);
      add("beq1_beq",   1, 7'h63, 1, 1, BQ1);
      add("beq0_fetch", 1, 7'h63, 1, 0, FETCH_OK);
      add("beq0_dec",   1, 7'h63, 1, 0, DEC);
      add("beq0_beq",   1, 7'h63, 1, 0, BQ0);
      // reset asserted for 3 cycles in the middle of a store
      add("sw2_fetch",  1, 7'h23, 1, 0, FETCH_OK);
      add("sw2_dec",    1, 7'h23, 1, 0, DEC);
      add("sw2_memadr", 1, 7'h23, 1, 0, MADR);
      add("sw2_memwr",  1, 7'h23, 0, 0, MWR);
      add("sw2_rst1",   0, 7'h23, 0, 0, MWR_RST);
      add("sw2_rst2",   0, 7'h23, 0, 0, FETCH_GATED);
      add("sw2_rst3",   0, 7'h23, 0, 0, FETCH_GATED);
      add("sw2_release",1, 7'h23, 0, 0, FETCH_WAIT);
      // op 1101111
      add("jal_fetch",  1, 7'h6F, 1, 0, FETCH_OK);
      add("jal_dec",    1, 7'h6F, 1, 0, DEC);
`ifdef MC_JAL_EN
      add("jal_jal",    1, 7'h6F, 1, 0, JL);
      add("jal_aluwb",  1, 7'h6F, 1, 0, AWB);
`else
      add("jal_fault",  1, 7'h6F, 1, 0, FLT);
      add("jal_fault2", 1, 7'h6F, 1, 0, FLT);
      add("jal_rst_a",  0, 7'h6F, 1, 0, FLT);
      add("jal_rst_b",  0, 7'h6F, 1, 0, FETCH_GATED);
`endif
      // other illegal opcode
      add("ill_fetch",  1, 7'h00, 1, 0, FETCH_OK);
      add("ill_dec",    1, 7'h00, 1, 0, DEC);
      add("ill_fault",  1, 7'h00, 1, 0, FLT);
      add("ill_fault2", 1, 7'h00, 1, 0, FLT);
      add("ill_rst_a",  0, 7'h00, 1, 0, FLT);
      add("ill_rst_b",  0, 7'h00, 1, 0, FETCH_GATED);
      // mem_ready arriving exactly at the timeout count wins
      for (int i = 0; i < 15; i++) add("win_wait", 1, 7'h33, 0, 0, FETCH_WAIT);
      add("win_ready",  1, 7'h33, 1, 0, FETCH_OK);
      add("win_dec",    1, 7'h33, 1, 0, DEC);
      add("win_execr",  1, 7'h33, 1, 0, EXR);
      add("win_aluwb",  1, 7'h33, 1, 0, AWB);
      // memory never answers: 16 FETCH cycles then sticky fault
      for (int i = 0; i < 15; i++) add("to_wait", 1, 7'h33, 0, 0, FETCH_WAIT);
      add("to_expire",  1, 7'h33, 0, 0, FETCH_GATED);
      for (int i = 0; i < 3; i++) add("to_sticky", 1, 7'h33, 1, 0, FLT);
      add("to_rst_a",   0, 7'h33, 1, 0, FLT);
      add("to_rst_b",   0, 7'h33, 1, 0, FETCH_GATED);
      add("to_recover", 1, 7'h33, 1, 0, FETCH_OK);

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("reset_state", state_o, ST_FETCH);
      check_val("reset_enables", {1'b0, mem_req | mem_write, ir_write | pc_write, reg_write | fault}, 4'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst_n     = vecs[i].rst;
         op        = vecs[i].op;
         mem_ready = vecs[i].mr;
         zero      = vecs[i].z;
         sb_q.push_back(vecs[i].exp);
         #1;
         got = {state_o, mem_req, mem_write, adr_src, ir_write, pc_write,
                alu_src_a, alu_src_b, result_src, reg_write, aluop, fault};
         exp = sb_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got st=%0d req=%b wr=%b adr=%b irw=%b pcw=%b sa=%b sb=%b rs=%b rw=%b ao=%b flt=%b, want st=%0d req=%b wr=%b adr=%b irw=%b pcw=%b sa=%b sb=%b rs=%b rw=%b ao=%b flt=%b",
                     vecs[i].tag, i,
                     got.st, got.req, got.wr, got.adr, got.irw, got.pcw, got.sa, got.sb, got.rs, got.rw, got.ao, got.flt,
                     exp.st, exp.req, exp.wr, exp.adr, exp.irw, exp.pcw, exp.sa, exp.sb, exp.rs, exp.rw, exp.ao, exp.flt);
         end
      end

      @(negedge clk);
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      op        = 7'h33;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      check_val("wait_not_expired", {3'b000, fault}, 4'h0);
      @(posedge clk);
      #1;
      check_val("wait_expired_state", state_o, ST_FAULT);
      check_val("wait_expired_flags", {2'b00, fault, mem_req}, 4'h2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
